// File: rtl/gate_truth_checker.sv
// Applies AB = 00,01,10,11 to a 2-input gate, samples F on the last hold cycle of
// each vector and scores it against a latched truth table. Option: GATE_CHK_STOP_ON_FAIL_EN.
module gate_truth_checker #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] truth_table,
  output logic       stim_a,
  output logic       stim_b,
  input  logic       dut_f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int            CW       = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [1:0]    r_idx, w_idx;
  logic [3:0]    r_tt, w_tt;
  logic [2:0]    r_err, w_err;
  logic [3:0]    r_fail, w_fail;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          r_pass, w_pass;
  logic          w_sample, w_mismatch, w_finish;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_idx      = r_idx;
    w_tt       = r_tt;
    w_err      = r_err;
    w_fail     = r_fail;
    w_busy     = r_busy;
    w_done     = r_done;
    w_pass     = r_pass;
    w_sample   = 1'b0;
    w_mismatch = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state = S_RUN;
          w_tt    = truth_table;
          w_err   = 3'd0;
          w_fail  = 4'd0;
          w_done  = 1'b0;
          w_pass  = 1'b0;
          w_idx   = 2'd0;
          w_cnt   = '0;
          w_busy  = 1'b1;
        end
      end
      S_RUN: begin
        w_sample   = (r_cnt == LAST_CNT);
        w_mismatch = w_sample && (dut_f != r_tt[r_idx]);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        w_finish   = w_sample && (w_mismatch || (r_idx == 2'd3));
`else
        w_finish   = w_sample && (r_idx == 2'd3);
`endif
        if (w_mismatch) begin
          w_err         = r_err + 3'd1;
          w_fail[r_idx] = 1'b1;
        end
        // Stimulus index is left untouched on finish so the last applied vector stays driven.
        if (w_finish) begin
          w_state = S_DONE;
          w_cnt   = '0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_pass  = (w_err == 3'd0);
        end else if (w_sample) begin
          w_idx = r_idx + 2'd1;
          w_cnt = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_tt    <= 4'd0;
      r_err   <= 3'd0;
      r_fail  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_tt    <= w_tt;
      r_err   <= w_err;
      r_fail  <= w_fail;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_pass  <= w_pass;
    end
  end

  assign stim_a    = r_idx[1];
  assign stim_b    = r_idx[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (HOLD 10 and HOLD 2) driven by a gate
// model; expected results queued at start and compared when done rises.
module tb_gate_truth_checker;

  localparam int H0 = 10;
  localparam int H1 = 2;

  typedef enum int {G_AND, G_OR, G_XOR, G_XNOR, G_ZERO} gate_e;

  typedef struct {
    logic       pass;
    logic [2:0] err;
    logic [3:0] fail;
    int         last;
    int         lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      truth_table;
  logic [1:0]      st, sa, sb, bsy, dn, ps, f;
  logic [1:0][2:0] ec;
  logic [1:0][3:0] fv;
  gate_e           kind;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic gate_f(gate_e g, logic a, logic b);
    case (g)
      G_AND:   return a & b;
      G_OR:    return a | b;
      G_XOR:   return a ^ b;
      G_XNOR:  return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  assign f = {gate_f(kind, sa[1], sb[1]), gate_f(kind, sa[0], sb[0])};

  gate_truth_checker #(.HOLD_CYCLES(H0)) u_dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .truth_table(truth_table),
    .stim_a(sa[0]), .stim_b(sb[0]), .dut_f(f[0]), .busy(bsy[0]), .done(dn[0]),
    .pass(ps[0]), .err_count(ec[0]), .fail_vec(fv[0])
  );

  gate_truth_checker #(.HOLD_CYCLES(H1)) u_dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .truth_table(truth_table),
    .stim_a(sa[1]), .stim_b(sb[1]), .dut_f(f[1]), .busy(bsy[1]), .done(dn[1]),
    .pass(ps[1]), .err_count(ec[1]), .fail_vec(fv[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic exp_t predict(gate_e g, logic [3:0] tt, int hold);
    exp_t       e;
    bit         stopped;
    logic [1:0] v;
    stopped = 1'b0;
    e.err   = 3'd0;
    e.fail  = 4'd0;
    e.last  = 3;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      if (!stopped && (gate_f(g, v[1], v[0]) != tt[i])) begin
        e.err     = e.err + 3'd1;
        e.fail[i] = 1'b1;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        stopped = 1'b1;
        e.last  = i;
`endif
      end
    end
    e.pass = (e.err == 3'd0);
    e.lat  = hold * (e.last + 1);
    return e;
  endfunction

  task automatic check_idle(input int sel, input string tag);
    check({tag, "_stim"}, {sa[sel], sb[sel]}, 0);
    check({tag, "_busy"}, bsy[sel], 0);
    check({tag, "_done"}, dn[sel], 0);
    check({tag, "_pass"}, ps[sel], 0);
    check({tag, "_err"},  ec[sel], 0);
    check({tag, "_fail"}, fv[sel], 0);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run(input int sel, input gate_e g, input logic [3:0] tt,
                     input int repulse_at, input logic [3:0] tt_mid, input int rst_at);
    int   hold;
    int   c;
    bit   seen;
    exp_t e;
    hold        = (sel == 0) ? H0 : H1;
    kind        = g;
    truth_table = tt;
    sb_q.push_back(predict(g, tt, hold));
    st[sel] = 1'b1;
    @(posedge clk); #1;
    st[sel] = 1'b0;
    check("start_err_clr",  ec[sel], 0);
    check("start_fail_clr", fv[sel], 0);
    c    = 0;
    seen = 1'b0;
    while (c <= 4 * hold + 4) begin
      if (dn[sel]) begin
        seen = 1'b1;
        break;
      end
      check("stim", {sa[sel], sb[sel]}, c / hold);
      check("busy", bsy[sel], 1);
      if (c == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle(sel, "abort");
        sb_q.delete(0);
        return;
      end
      if (c == repulse_at) begin
        st[sel]     = 1'b1;
        truth_table = tt_mid;
      end
      @(posedge clk); #1;
      st[sel] = 1'b0;
      c++;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("latency",   c, e.lat);
    check("pass",      ps[sel], e.pass);
    check("err_count", ec[sel], e.err);
    check("fail_vec",  fv[sel], e.fail);
    check("done_stim", {sa[sel], sb[sel]}, e.last);
    check("done_busy", bsy[sel], 0);
    @(posedge clk); #1;
    check("done_hold", dn[sel], 1);
    check("stim_hold", {sa[sel], sb[sel]}, e.last);
  endtask

  initial begin
    rst         = 1'b1;
    st          = 2'b00;
    truth_table = 4'd0;
    kind        = G_ZERO;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle(0, "reset0");
    check_idle(1, "reset1");

    // start and rst on the same edge: reset wins
    rst   = 1'b1;
    st[0] = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    st[0] = 1'b0;
    check_idle(0, "rst_vs_start");

    run(0, G_XNOR, 4'b1001, -1, 4'b0000, -1);
    run(0, G_ZERO, 4'b1001, -1, 4'b0000, -1);
    run(0, G_AND,  4'b1001, -1, 4'b0000, -1);
    run(0, G_AND,  4'b1000, -1, 4'b0000, -1);
    run(0, G_OR,   4'b0001, -1, 4'b0000, -1);
    run(0, G_XOR,  4'b0110, 15, 4'b1111, -1);
    run(0, G_OR,   4'b1110, -1, 4'b0000, 25);
    run(0, G_OR,   4'b1110, -1, 4'b0000, -1);
    run(1, G_XNOR, 4'b1001, -1, 4'b0000, -1);
    run(1, G_ZERO, 4'b1001, -1, 4'b0000, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
